mem_port_arbiter: RTL and testbench

//  Shares one port of the unified instruction/data block RAM between two requesters.
//   - CPU: the control FSM's fetch/load/store path (primary).
//   - IO: display/peripheral DMA engine (secondary).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 22 ++
 rtl/mem_port_arbiter_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
// Purpose: FSM state and owner encodings, counter widths, saturating increment.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RDWAIT = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_IO  = 1'b1
   } owner_e;

   // STARVE_MAX is legal up to 15, READ_LAT up to 7 (lat_cnt holds READ_LAT-1).
   localparam int STARVE_W = 4;
   localparam int LAT_W    = 3;

   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                   input logic [STARVE_W-1:0] max_v);
      return (v >= max_v) ? max_v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side access port bundle
// Purpose: one requester's request/grant/read-return signals.
//   master: requester (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave : arbiter   (receives req/we/addr/wdata, drives gnt/rvalid/rdata)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   import mem_port_arbiter_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - combinational winner selection
// Purpose: CPU has priority unless IO has been passed over STARVE_MAX times.
// Ports:
//   cpu_req_i, io_req_i : pending requests
//   starve_cnt_i        : consecutive CPU wins over a waiting IO
//   winner_o            : owner id of the access to start
//   any_req_o           : at least one request pending
module mem_port_arbiter_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                cpu_req_i,
   input  logic                io_req_i,
   input  logic [STARVE_W-1:0] starve_cnt_i,
   output owner_e              winner_o,
   output logic                any_req_o
);

   assign any_req_o = cpu_req_i | io_req_i;
   assign winner_o  = (io_req_i && (!cpu_req_i || starve_cnt_i == STARVE_W'(STARVE_MAX)))
                      ? OWN_IO : OWN_CPU;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for one block RAM port
// Purpose: shares a BRAM port between CPU (priority) and IO (starvation guarded),
//          one access in flight, returns a read-valid pulse after READ_LAT cycles.
// Ports:
//   clk_i, reset_i     : clock, asynchronous active-high reset
//   cpu, io            : requester ports (slave side)
//   mem_addr_o/wdata_o : registered BRAM address / write data
//   mem_wren_o         : registered BRAM write enable
//   mem_rdata_i        : BRAM read data, forwarded to both requesters
//   busy_o             : FSM not idle
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int READ_LAT   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   mem_port_arbiter_if.slave cpu,
   mem_port_arbiter_if.slave io,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_wren_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   state_e              state_q;
   owner_e              owner_q;
   logic [LAT_W-1:0]    lat_cnt_q;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                mem_wren_q;
   logic                cpu_gnt_q, io_gnt_q, cpu_rvalid_q, io_rvalid_q;

   owner_e              winner;
   logic                any_req;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   mem_port_arbiter_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .cpu_req_i    (cpu.req),
      .io_req_i     (io.req),
      .starve_cnt_i (starve_cnt_q),
      .winner_o     (winner),
      .any_req_o    (any_req)
   );

   always_comb begin
      sel_we       = cpu.we;
      sel_addr     = cpu.addr;
      sel_wdata    = cpu.wdata;
      starve_cnt_d = '0;
      if (winner == OWN_IO) begin
         sel_we    = io.we;
         sel_addr  = io.addr;
         sel_wdata = io.wdata;
      end
      // Only a CPU win over a waiting IO advances the guard; anything else clears it.
      if (io.req && winner == OWN_CPU) begin
         starve_cnt_d = sat_inc(starve_cnt_q, STARVE_W'(STARVE_MAX));
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_CPU;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wren_q   <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         io_gnt_q     <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         io_rvalid_q  <= 1'b0;
      end else begin
         cpu_gnt_q    <= 1'b0;
         io_gnt_q     <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         io_rvalid_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               starve_cnt_q <= starve_cnt_d;
               if (any_req) begin
                  // Captured straight into the memory-side registers, so later
                  // requester changes cannot disturb the access in flight.
                  owner_q     <= winner;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  mem_wren_q  <= sel_we;
                  cpu_gnt_q   <= (winner == OWN_CPU);
                  io_gnt_q    <= (winner == OWN_IO);
                  state_q     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               mem_wren_q <= 1'b0;
               if (mem_wren_q) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q   <= ST_RDWAIT;
                  lat_cnt_q <= LAT_W'(READ_LAT - 1);
                  // rvalid is registered: raise it on the edge entering lat_cnt==0.
                  if (READ_LAT == 1) begin
                     cpu_rvalid_q <= (owner_q == OWN_CPU);
                     io_rvalid_q  <= (owner_q == OWN_IO);
                  end
               end
            end
            ST_RDWAIT: begin
               if (lat_cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 1'b1;
                  if (lat_cnt_q == LAT_W'(1)) begin
                     cpu_rvalid_q <= (owner_q == OWN_CPU);
                     io_rvalid_q  <= (owner_q == OWN_IO);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wren_o  = mem_wren_q;
   assign busy_o      = (state_q != ST_IDLE);

   assign cpu.gnt    = cpu_gnt_q;
   assign cpu.rvalid = cpu_rvalid_q;
   assign cpu.rdata  = mem_rdata_i;
   assign io.gnt     = io_gnt_q;
   assign io.rvalid  = io_rvalid_q;
   assign io.rdata   = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wren, busy;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) io_if ();

   mem_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .READ_LAT(2), .STARVE_MAX(4)
   ) dut (
      .clk_i       (clk),
      .reset_i     (rst),
      .cpu         (cpu_if),
      .io          (io_if),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_wren_o  (mem_wren),
      .mem_rdata_i (mem_rdata),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Registered-output BRAM, two cycles from address presentation to data.
   logic [15:0] mem [0:65535];
   logic [15:0] rd1, rd2;
   always @(posedge clk) begin
      if (rst) mem[16'h0040] <= 16'h1234;
      if (mem_wren) mem[mem_addr] <= mem_wdata;
      rd1 <= mem[mem_addr];
      rd2 <= rd1;
   end
   assign mem_rdata = rd2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
      io_if.req  = 0; io_if.we  = 0; io_if.addr  = '0; io_if.wdata  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cpu_gnt", cpu_if.gnt, 0);
      chk("rst_io_gnt", io_if.gnt, 0);
      chk("rst_cpu_rvalid", cpu_if.rvalid, 0);
      chk("rst_io_rvalid", io_if.rvalid, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      rst = 1'b0;

      // CPU read 0x0040; address changes right after capture
      cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 16'h0040;
      @(negedge clk);
      chk("rd_cpu_gnt", cpu_if.gnt, 1);
      chk("rd_io_gnt", io_if.gnt, 0);
      chk("rd_addr", mem_addr, 16'h0040);
      chk("rd_wren", mem_wren, 0);
      chk("rd_busy", busy, 1);
      cpu_if.req = 0; cpu_if.addr = 16'h0041;
      @(negedge clk);
      chk("rd_wait_gnt", cpu_if.gnt, 0);
      chk("rd_wait_rvalid", cpu_if.rvalid, 0);
      chk("rd_addr_held", mem_addr, 16'h0040);
      @(negedge clk);
      chk("rd_rvalid", cpu_if.rvalid, 1);
      chk("rd_rdata", cpu_if.rdata, 16'h1234);
      chk("rd_io_rvalid", io_if.rvalid, 0);
      @(negedge clk);
      chk("rd_done_rvalid", cpu_if.rvalid, 0);
      chk("rd_done_busy", busy, 0);

      // IO write 0x8000 <= 0xBEEF, then readback
      io_if.req = 1; io_if.we = 1; io_if.addr = 16'h8000; io_if.wdata = 16'hBEEF;
      @(negedge clk);
      chk("wr_io_gnt", io_if.gnt, 1);
      chk("wr_cpu_gnt", cpu_if.gnt, 0);
      chk("wr_wren", mem_wren, 1);
      chk("wr_addr", mem_addr, 16'h8000);
      chk("wr_wdata", mem_wdata, 16'hBEEF);
      io_if.req = 0; io_if.we = 0;
      @(negedge clk);
      chk("wr_wren_off", mem_wren, 0);
      chk("wr_idle", busy, 0);
      io_if.req = 1;
      @(negedge clk);
      chk("rb_io_gnt", io_if.gnt, 1);
      io_if.req = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rb_io_rvalid", io_if.rvalid, 1);
      chk("rb_io_rdata", io_if.rdata, 16'hBEEF);
      chk("rb_cpu_rvalid", cpu_if.rvalid, 0);
      @(negedge clk);
      chk("rb_idle", busy, 0);

      // Both held high: four CPU grants then one IO grant, repeating
      cpu_if.req = 1; cpu_if.we = 1; cpu_if.addr = 16'h0100; cpu_if.wdata = 16'h0001;
      io_if.req  = 1; io_if.we  = 1; io_if.addr  = 16'h0200; io_if.wdata  = 16'h0002;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("starve_cpu_gnt_%0d", k), cpu_if.gnt, (k == 4 || k == 9) ? 0 : 1);
         chk($sformatf("starve_io_gnt_%0d", k), io_if.gnt, (k == 4 || k == 9) ? 1 : 0);
         @(negedge clk);
         chk($sformatf("starve_idle_%0d", k), busy, 0);
      end
      cpu_if.req = 0; io_if.req = 0;
      @(negedge clk);
      chk("starve_end_busy", busy, 0);

      // Both requests rise together straight out of reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cpu_if.req = 1; cpu_if.we = 1; cpu_if.addr = 16'h0300; cpu_if.wdata = 16'h0003;
      io_if.req  = 1; io_if.we  = 1; io_if.addr  = 16'h0301; io_if.wdata  = 16'h0004;
      @(negedge clk);
      chk("sim_cpu_first", cpu_if.gnt, 1);
      chk("sim_io_not_first", io_if.gnt, 0);
      chk("sim_cpu_addr", mem_addr, 16'h0300);
      cpu_if.req = 0;
      @(negedge clk);
      chk("sim_idle", busy, 0);
      @(negedge clk);
      chk("sim_io_second", io_if.gnt, 1);
      chk("sim_cpu_not_second", cpu_if.gnt, 0);
      chk("sim_io_addr", mem_addr, 16'h0301);
      chk("sim_io_wdata", mem_wdata, 16'h0004);
      io_if.req = 0; io_if.we = 0; cpu_if.we = 0;
      @(negedge clk);
      chk("sim_done", busy, 0);

      // Reset asserted during RDWAIT
      cpu_if.req = 1; cpu_if.addr = 16'h0040;
      @(negedge clk);
      chk("ar_cpu_gnt", cpu_if.gnt, 1);
      cpu_if.req = 0;
      @(negedge clk);
      chk("ar_rdwait_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_cpu_gnt0", cpu_if.gnt, 0);
      chk("ar_cpu_rvalid0", cpu_if.rvalid, 0);
      chk("ar_wren", mem_wren, 0);
      chk("ar_addr", mem_addr, 0);
      chk("ar_wdata", mem_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("ar_no_rvalid_%0d", k), cpu_if.rvalid, 0);
         chk($sformatf("ar_idle_%0d", k), busy, 0);
      end
      cpu_if.req = 1; cpu_if.addr = 16'h8000;
      @(negedge clk);
      chk("ar2_cpu_gnt", cpu_if.gnt, 1);
      cpu_if.req = 0;
      @(negedge clk);
      @(negedge clk);
      chk("ar2_rvalid", cpu_if.rvalid, 1);
      chk("ar2_rdata", cpu_if.rdata, 16'hBEEF);
      @(negedge clk);
      chk("ar2_done_rvalid", cpu_if.rvalid, 0);
      chk("ar2_done_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
